// File: rtl/x_byte_delay_fifo.sv
// Timed byte FIFO: each captured byte is held at least p_delay cycles before it is offered downstream.
// Optional build macro X_BYTE_DELAY_DROP_CNT_EN adds an 8-bit saturating dropped-byte counter (o_drop_cnt).
module x_byte_delay_fifo #(
   parameter int p_depth = 16,
   parameter int p_delay = 50000
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_valid,
   input  logic [7:0]                   i_data,
   output logic                         o_valid,
   output logic [7:0]                   o_data,
   input  logic                         i_accept,
   output logic [$clog2(p_depth):0]     o_count,
   output logic                         o_full,
`ifdef X_BYTE_DELAY_DROP_CNT_EN
   output logic [7:0]                   o_drop_cnt,
`endif
   output logic                         o_overflow
);

   localparam int p_ts_w  = $clog2(p_delay + 1) + 1;
   localparam int p_ptr_w = $clog2(p_depth);
   localparam int p_cnt_w = p_ptr_w + 1;

   localparam logic [p_ts_w-1:0]  c_delay = p_ts_w'(p_delay);
   localparam logic [p_cnt_w-1:0] c_depth = p_cnt_w'(p_depth);
   localparam logic               c_zero_delay = (p_delay == 0);

   logic [p_ts_w-1:0]  ts_now;
   logic [7:0]         mem_data [p_depth];
   logic [p_ts_w-1:0]  mem_ts   [p_depth];
   logic [p_depth-1:0] occ;
   logic [p_depth-1:0] matured;
   logic [p_depth-1:0] ripe;
   logic [p_ptr_w-1:0] wptr;
   logic [p_ptr_w-1:0] rptr;
   logic [p_ptr_w-1:0] rptr_nxt;
   logic [p_cnt_w-1:0] count_nxt;
   logic               push;
   logic               pop;
   logic               drop;
   logic               valid_nxt;

   assign o_full = (o_count == c_depth);

   always_comb begin
      pop  = o_valid & i_accept;
      push = i_valid & (~o_full | pop);
      drop = i_valid & o_full & ~pop;

      rptr_nxt = pop ? rptr + p_ptr_w'(1) : rptr;

      case ({push, pop})
         2'b10:   count_nxt = o_count + p_cnt_w'(1);
         2'b01:   count_nxt = o_count - p_cnt_w'(1);
         default: count_nxt = o_count;
      endcase

      // Exact-equality age test: an entry ripens once per timestamp period and the
      // sticky matured bit keeps it ripe, so counter wrap cannot un-mature a stalled head.
      ripe = '0;
      for (int i = 0; i < p_depth; i++) begin
         ripe[i] = occ[i] && ((ts_now - mem_ts[i]) == c_delay);
      end

      // Uses pre-edge matured bits, giving the one extra registered cycle of latency.
      valid_nxt = (count_nxt != '0) && matured[rptr_nxt];
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         mem_data[wptr] <= i_data;
         mem_ts[wptr]   <= ts_now;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ts_now     <= '0;
         wptr       <= '0;
         rptr       <= '0;
         occ        <= '0;
         matured    <= '0;
         o_count    <= '0;
         o_valid    <= 1'b0;
         o_data     <= 8'h00;
         o_overflow <= 1'b0;
      end else begin
         ts_now <= ts_now + p_ts_w'(1);

         matured <= matured | ripe;

         if (pop) begin
            occ[rptr]     <= 1'b0;
            matured[rptr] <= 1'b0;
         end

         // Push after pop so a full-FIFO swap on the same slot keeps the new entry.
         if (push) begin
            occ[wptr]     <= 1'b1;
            matured[wptr] <= c_zero_delay;
            wptr          <= wptr + p_ptr_w'(1);
         end

         rptr    <= rptr_nxt;
         o_count <= count_nxt;
         o_valid <= valid_nxt;

         if (valid_nxt) begin
            o_data <= mem_data[rptr_nxt];
         end

         if (drop) begin
            o_overflow <= 1'b1;
         end
      end
   end

`ifdef X_BYTE_DELAY_DROP_CNT_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_drop_cnt <= 8'h00;
      end else if (drop && (o_drop_cnt != 8'hFF)) begin
         o_drop_cnt <= o_drop_cnt + 8'h01;
      end
   end
`endif

endmodule

// File: tb/tb_x_byte_delay_fifo.sv
// Scoreboard bench for x_byte_delay_fifo: directed pushes feed an expected-byte queue,
// a negedge monitor checks every presented head byte; directed checks cover latency, full, overflow, reset.
module tb_x_byte_delay_fifo;

   logic       clk = 1'b0;
   logic       rst;

   logic       a_valid, a_accept;
   logic [7:0] a_data;
   logic       a_o_valid, a_full, a_overflow;
   logic [7:0] a_o_data;
   logic [2:0] a_count;

   logic       b_valid, b_accept;
   logic [7:0] b_data;
   logic       b_o_valid, b_full, b_overflow;
   logic [7:0] b_o_data;
   logic [2:0] b_count;

`ifdef X_BYTE_DELAY_DROP_CNT_EN
   logic [7:0] a_drop_cnt, b_drop_cnt;
`endif

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] sb [$];

   always #5 clk = ~clk;

   x_byte_delay_fifo #(.p_depth(4), .p_delay(10)) dut_a (
      .i_clk(clk), .i_rst(rst),
      .i_valid(a_valid), .i_data(a_data),
      .o_valid(a_o_valid), .o_data(a_o_data), .i_accept(a_accept),
      .o_count(a_count), .o_full(a_full),
`ifdef X_BYTE_DELAY_DROP_CNT_EN
      .o_drop_cnt(a_drop_cnt),
`endif
      .o_overflow(a_overflow)
   );

   x_byte_delay_fifo #(.p_depth(4), .p_delay(0)) dut_b (
      .i_clk(clk), .i_rst(rst),
      .i_valid(b_valid), .i_data(b_data),
      .o_valid(b_o_valid), .o_data(b_o_data), .i_accept(b_accept),
      .o_count(b_count), .o_full(b_full),
`ifdef X_BYTE_DELAY_DROP_CNT_EN
      .o_drop_cnt(b_drop_cnt),
`endif
      .o_overflow(b_overflow)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every presented head must match the oldest expected byte; a handshake retires it.
   always @(negedge clk) begin
      if (!rst && a_o_valid) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_output: got 0x%0h expected no byte at %0t", a_o_data, $time);
         end else begin
            if (a_o_data !== sb[0]) begin
               miscompares++;
               $display("FAIL head_data: got 0x%0h expected 0x%0h at %0t", a_o_data, sb[0], $time);
            end
            if (a_accept) void'(sb.pop_front());
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_a(input logic [7:0] d, input bit expect_keep);
      a_valid = 1'b1;
      a_data  = d;
      if (expect_keep) sb.push_back(d);
      tick(1);
      a_valid = 1'b0;
   endtask

   // Push into empty FIFO with i_accept already high; o_valid must rise after edge 11 exactly.
   task automatic latency_a(input logic [7:0] d);
      push_a(d, 1'b1);
      for (int j = 1; j <= 11; j++) begin
         tick(1);
         if (j == 10) begin
            chk("lat_not_early", a_o_valid, 0);
            chk("accept_ignored_count", a_count, 1);
         end
      end
      chk("lat_valid", a_o_valid, 1);
      chk("lat_data", a_o_data, d);
      tick(1);
      chk("after_pop_count", a_count, 0);
      chk("after_pop_valid", a_o_valid, 0);
   endtask

   initial begin
      rst = 1'b1;
      a_valid = 1'b0; a_data = 8'h00; a_accept = 1'b0;
      b_valid = 1'b0; b_data = 8'h00; b_accept = 1'b1;
      #3;
      chk("rst_valid", a_o_valid, 0);
      chk("rst_data", a_o_data, 0);
      chk("rst_count", a_count, 0);
      chk("rst_full", a_full, 0);
      chk("rst_overflow", a_overflow, 0);
      tick(2);
      rst = 1'b0;

      // single byte latency
      a_accept = 1'b1;
      latency_a(8'hA5);

      // long stall across timestamp wraps, then back-to-back delivery
      a_accept = 1'b0;
      push_a(8'h01, 1'b1);
      push_a(8'h02, 1'b1);
      push_a(8'h03, 1'b1);
      tick(100);
      chk("stall_valid", a_o_valid, 1);
      chk("stall_count", a_count, 3);
      a_accept = 1'b1;
      tick(1);
      chk("b2b_valid1", a_o_valid, 1);
      chk("b2b_count1", a_count, 2);
      tick(1);
      chk("b2b_valid2", a_o_valid, 1);
      chk("b2b_count2", a_count, 1);
      tick(1);
      chk("b2b_valid3", a_o_valid, 0);
      chk("b2b_count3", a_count, 0);
      a_accept = 1'b0;

      // full FIFO with matured head: same-edge push and pop
      push_a(8'h20, 1'b1);
      push_a(8'h21, 1'b1);
      push_a(8'h22, 1'b1);
      push_a(8'h23, 1'b1);
      chk("fill_full", a_full, 1);
      chk("fill_count", a_count, 4);
      tick(12);
      chk("full_head_valid", a_o_valid, 1);
      a_accept = 1'b1;
      push_a(8'h77, 1'b1);
      a_accept = 1'b0;
      chk("swap_count", a_count, 4);
      chk("swap_full", a_full, 1);
      chk("swap_overflow", a_overflow, 0);
      a_accept = 1'b1;
      tick(20);
      chk("drain_count", a_count, 0);
      a_accept = 1'b0;

      // overflow: fifth byte dropped
      push_a(8'h10, 1'b1);
      push_a(8'h11, 1'b1);
      push_a(8'h12, 1'b1);
      push_a(8'h13, 1'b1);
      push_a(8'h14, 1'b0);
      chk("ovf_flag", a_overflow, 1);
      chk("ovf_full", a_full, 1);
      chk("ovf_count", a_count, 4);
`ifdef X_BYTE_DELAY_DROP_CNT_EN
      chk("ovf_drop_cnt", a_drop_cnt, 1);
`endif

      // reset mid-handshake with three entries held
      tick(12);
      a_accept = 1'b1;
      tick(1);
      chk("pre_rst_count", a_count, 3);
      chk("pre_rst_valid", a_o_valid, 1);
      #1;
      rst = 1'b1;
      sb.delete();
      #1;
      chk("async_rst_valid", a_o_valid, 0);
      chk("async_rst_count", a_count, 0);
      chk("async_rst_full", a_full, 0);
      chk("async_rst_overflow", a_overflow, 0);
`ifdef X_BYTE_DELAY_DROP_CNT_EN
      chk("async_rst_drop_cnt", a_drop_cnt, 0);
`endif
      tick(2);
      rst = 1'b0;
      latency_a(8'h5A);

      // zero delay instance
      b_valid = 1'b1;
      b_data  = 8'h3C;
      tick(1);
      b_valid = 1'b0;
      chk("d0_not_early", b_o_valid, 0);
      tick(1);
      chk("d0_valid", b_o_valid, 1);
      chk("d0_data", b_o_data, 8'h3C);
      tick(1);
      chk("d0_count", b_count, 0);

      tick(2);
      chk("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
